// File: rtl/uart_tx_engine.sv
`timescale 1ns/1ps
// uart_tx_engine: pops one byte from the TX FIFO and sends it as start/8 data (LSB first)/[even parity]/stop.
// Latency: start condition seen at edge E -> start bit and pop strobe in the cycle after E; frame is (10+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: a new frame starts only when enable=1 and the FIFO is non-empty; enable never aborts a frame in progress.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_rdata,
  output logic       fifo_renable,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  // Cycle counter is at least one bit wide even for the smallest legal divider.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic          ren_q;
  logic          tx_q;
  logic          busy_q;
  logic          done_q;
  logic          bit_end;

  // Bit boundary and wrapping cycle count, shared by every non-idle state.
  always_comb begin
    bit_end = (cnt_q == CNT_LAST);
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
  end

  // Frame sequencer; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      ren_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Pop and done are single-cycle strobes unless re-asserted below.
      ren_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          cnt_q  <= '0;
          bit_q  <= '0;
          if (enable && !fifo_empty) begin
            // Capture the head before popping so later head changes cannot leak in.
            shift_q <= fifo_rdata;
            par_q   <= ^fifo_rdata;
            ren_q   <= 1'b1;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            shift_q <= {1'b0, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              if (PARITY_EN) begin
                tx_q    <= par_q;
                state_q <= PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        PARITY: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            tx_q    <= 1'b1;
            state_q <= STOP;
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          // Raise done one edge early so it lines up with the final stop cycle.
          if (cnt_q == CNT_PENULT) begin
            done_q <= 1'b1;
          end
          if (bit_end) begin
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign fifo_renable = ren_q;
  assign tx_out       = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
`timescale 1ns/1ps
// Bench for uart_tx_engine: two instances (no parity / even parity) at CLKS_PER_BIT=4,
// each fed by a small show-ahead FIFO model; frames are checked cycle by cycle
// against bit sequences from a table or from a byte-level frame model.
module tb_uart_tx_engine;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       enable;
  logic [1:0] empty_w, ren_w, tx_w, busy_w, done_w;
  logic [7:0] rdata_w [2];

  logic [7:0] mem [2][16];
  int wr [2];
  int rd [2];
  int pops [2];
  int underflow;
  int checks = 0;
  int failures = 0;
  int g1;

  assign empty_w[0] = (rd[0] == wr[0]);
  assign empty_w[1] = (rd[1] == wr[1]);
  assign rdata_w[0] = mem[0][rd[0] % 16];
  assign rdata_w[1] = mem[1][rd[1] % 16];

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut0 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .fifo_empty(empty_w[0]),
    .fifo_rdata(rdata_w[0]), .fifo_renable(ren_w[0]), .tx_out(tx_w[0]),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]));

  uart_tx_engine #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut1 (
    .clk(clk), .n_rst(n_rst), .enable(enable), .fifo_empty(empty_w[1]),
    .fifo_rdata(rdata_w[1]), .fifo_renable(ren_w[1]), .tx_out(tx_w[1]),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]));

  // FIFO model read side: a strobe pops the head; a strobe on an empty FIFO is recorded.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ren_w[i] === 1'b1) begin
        pops[i] <= pops[i] + 1;
        if (rd[i] == wr[i]) underflow <= underflow + 1;
        else rd[i] <= rd[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wr[i] % 16] = b;
    wr[i] = wr[i] + 1;
  endtask

  // Frame model: line[n] is the level of bit time n.
  function automatic void model(input logic [7:0] b, input bit p,
                                output logic [10:0] line, output int nb);
    int ones;
    ones = 0;
    line = '0;
    nb = p ? 11 : 10;
    line[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      line[1 + k] = b[k];
      if (b[k]) ones++;
    end
    if (p) line[9] = (ones % 2 == 1);
    line[nb - 1] = 1'b1;
  endfunction

  // Waits for the pop strobe (first start cycle), checks every cycle of the frame,
  // then the idle cycle after it. gap = negedges waited until the start.
  task automatic run_frame(input int i, input logic [10:0] line, input int nb,
                           input string tag, output int gap);
    int p0;
    int len;
    p0 = pops[i];
    gap = 0;
    len = nb * CPB;
    do begin
      @(negedge clk);
      gap++;
    end while (ren_w[i] !== 1'b1 && gap < 60);
    if (ren_w[i] !== 1'b1) begin
      chk({tag, " start timeout"}, 32'(ren_w[i]), 1);
      return;
    end
    for (int c = 0; c < len; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("%s tx c%0d", tag, c), 32'(tx_w[i]), 32'(line[c / CPB]));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy_w[i]), 1);
      chk($sformatf("%s ren c%0d", tag, c), 32'(ren_w[i]), (c == 0) ? 1 : 0);
      chk($sformatf("%s done c%0d", tag, c), 32'(done_w[i]), (c == len - 1) ? 1 : 0);
    end
    @(negedge clk);
    chk({tag, " idle tx"}, 32'(tx_w[i]), 1);
    chk({tag, " idle busy"}, 32'(busy_w[i]), 0);
    chk({tag, " pops"}, pops[i] - p0, 1);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] d;
    logic [10:0] line;
    int         nb;
  } vec_t;

  initial begin
    vec_t vecs [6];
    logic [10:0] ln;
    int nb;
    int gap;
    int gap2;
    int p0;
    int w;
    logic [7:0] b;
    int i;

    vecs[0] = '{0, 8'hF0, 11'h3E0, 10};
    vecs[1] = '{1, 8'hA5, 11'h54A, 11};
    vecs[2] = '{1, 8'h07, 11'h60E, 11};
    vecs[3] = '{0, 8'h55, 11'h2AA, 10};
    vecs[4] = '{1, 8'hFF, 11'h5FE, 11};
    vecs[5] = '{0, 8'h00, 11'h200, 10};

    // Reset held with data waiting: line idles, nothing popped.
    n_rst = 1'b0;
    enable = 1'b1;
    push(0, 8'h81);
    repeat (4) begin
      @(negedge clk);
      chk("rst tx0", 32'(tx_w[0]), 1);
      chk("rst tx1", 32'(tx_w[1]), 1);
      chk("rst busy0", 32'(busy_w[0]), 0);
      chk("rst ren0", 32'(ren_w[0]), 0);
      chk("rst done0", 32'(done_w[0]), 0);
    end
    chk("rst pops", pops[0], 0);
    n_rst = 1'b1;
    model(8'h81, 1'b0, ln, nb);
    run_frame(0, ln, nb, "first", gap);
    chk("start latency", gap, 1);

    // Table-driven frames with hand-derived bit sequences.
    for (int v = 0; v < 6; v++) begin
      push(vecs[v].inst, vecs[v].d);
      run_frame(vecs[v].inst, vecs[v].line, vecs[v].nb, $sformatf("vec%0d", v), gap);
      chk($sformatf("vec%0d latency", v), gap, 1);
    end

    // Back-to-back: one idle cycle between frames, then stay idle.
    p0 = pops[0];
    push(0, 8'h55);
    push(0, 8'hAA);
    run_frame(0, 11'h2AA, 10, "b2b1", gap);
    run_frame(0, 11'h354, 10, "b2b2", gap2);
    chk("b2b gap", gap2, 1);
    repeat (8) begin
      @(negedge clk);
      chk("b2b idle busy", 32'(busy_w[0]), 0);
      chk("b2b idle ren", 32'(ren_w[0]), 0);
    end
    chk("b2b pops", pops[0] - p0, 2);

    // Enable dropped mid-DATA: frame completes, next byte waits.
    push(0, 8'h3C);
    push(0, 8'hC3);
    model(8'h3C, 1'b0, ln, nb);
    fork
      run_frame(0, ln, nb, "engate", g1);
      begin
        repeat (20) @(negedge clk);
        enable = 1'b0;
      end
    join
    p0 = pops[0];
    repeat (12) begin
      @(negedge clk);
      chk("engate idle busy", 32'(busy_w[0]), 0);
      chk("engate idle ren", 32'(ren_w[0]), 0);
    end
    chk("engate no pop", pops[0] - p0, 0);
    enable = 1'b1;
    model(8'hC3, 1'b0, ln, nb);
    run_frame(0, ln, nb, "reenable", gap);
    chk("reenable latency", gap, 1);

    // Reset during data bit 3: frame abandoned, no second pop.
    p0 = pops[0];
    push(0, 8'h5A);
    push(0, 8'h11);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ren_w[0] !== 1'b1 && w < 60);
    chk("midrst start", 32'(ren_w[0]), 1);
    repeat (17) @(negedge clk);
    chk("midrst d3", 32'(tx_w[0]), 1);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst tx", 32'(tx_w[0]), 1);
    chk("midrst busy", 32'(busy_w[0]), 0);
    chk("midrst ren", 32'(ren_w[0]), 0);
    chk("midrst done", 32'(done_w[0]), 0);
    repeat (5) begin
      @(negedge clk);
      chk("midrst hold ren", 32'(ren_w[0]), 0);
    end
    chk("midrst pops", pops[0] - p0, 1);
    n_rst = 1'b1;
    model(8'h11, 1'b0, ln, nb);
    run_frame(0, ln, nb, "postrst", gap);
    chk("postrst latency", gap, 1);

    // Random bytes on random instances against the frame model.
    for (int n = 0; n < 24; n++) begin
      i = int'($urandom_range(0, 1));
      b = 8'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      push(i, b);
      model(b, (i == 1), ln, nb);
      run_frame(i, ln, nb, $sformatf("rnd%0d", n), gap);
      chk($sformatf("rnd%0d latency", n), gap, 1);
    end

    repeat (3) @(negedge clk);
    chk("underflow", underflow, 0);
    chk("pops0 total", pops[0], wr[0]);
    chk("pops1 total", pops[1], wr[1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

- Serial transmitter at the read end of the serial block's 8-bit transmit FIFO wrapper.
- Whenever it is enabled and the FIFO holds data, it pops one byte and sends it on `tx_out` as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, stop bit.
- It drives the FIFO's read enable and consumes the FIFO's read data and empty flag.
- The APB register block supplies `enable`.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range 2..65535.
- `PARITY_EN`, default 0: 1 inserts an even-parity bit between data bit 7 and the stop bit.

- `clk`  in  1  system clock; all state updates on its rising edge.
- `n_rst`  in  1  reset, synchronous and active-low.
- `enable`  in  1  permits a new frame to start; does not abort a frame in progress.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdata`  in  8  FIFO head entry; show-ahead, valid whenever `fifo_empty`=0.
- `fifo_renable`  out  1  one-cycle pop strobe to the FIFO.
- `tx_out`  out  1  serial line; idles high.
- `tx_busy`  out  1  high while a frame is on the line.
- `tx_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- All outputs are registered.
- Reset values: `tx_out`=1, `fifo_renable`=0, `tx_busy`=0, `tx_done`=0. State is IDLE, counters are 0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx_out`=1. When `enable`=1 and `fifo_empty`=0 at an edge:
  - shift register <= `fifo_rdata`;
  - next cycle: `fifo_renable`=1, `tx_out`=0, `tx_busy`=1;
  - state -> START.
- START: holds 0 for CLKS_PER_BIT cycles, then -> DATA.
- DATA: drives shift register bit 0 and shifts right at each bit boundary. After 8 bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: drives the XOR of the 8 captured data bits (even parity), for CLKS_PER_BIT cycles.
- STOP: drives 1 for CLKS_PER_BIT cycles. On its final cycle `tx_done`=1. Then -> IDLE with `tx_busy`=0.
- Counters:
  - cycle counter width `$clog2(CLKS_PER_BIT)`, counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary;
  - bit counter 3 bits, wraps 7->0 on exit from DATA.
- Exactly one pop per frame. `fifo_renable` is never asserted while `fifo_empty`=1 or outside the first cycle of START.
- The data byte is captured before the pop, so FIFO head changes after the pop do not affect the frame.
- `enable` dropping mid-frame: the current frame completes, no new frame starts.
- `fifo_empty`=1 in IDLE: the block stays idle; no underflow read.
- `n_rst`=0 mid-frame: at the next edge all outputs take their reset values. The partial frame is abandoned, the byte is lost, no pop is issued.

## Timing
- Start latency: if the start condition is seen at edge E, `tx_out` falls and `fifo_renable` pulses in cycle E+1. The FIFO reflects the pop from E+2.
- Frame length: (10+PARITY_EN)×CLKS_PER_BIT cycles of `tx_busy`=1.
- Back-to-back frames: at least one IDLE cycle with `tx_out`=1 between the stop bit and the next start bit. The minimum frame-start to frame-start period is (10+PARITY_EN)×CLKS_PER_BIT+1 cycles.
- Bit boundaries are exact multiples of CLKS_PER_BIT counted from the start-bit cycle.

## Test plan
- **Reset:** reset asserted with FIFO holding data -> `tx_out`=1, `tx_busy`=0, no `fifo_renable` while reset is held.
- **Single frame:** CLKS_PER_BIT=4, PARITY_EN=0, head 0xF0, `enable`=1 ->
  - `tx_out` per bit: 0,0,0,0,0,1,1,1,1,1, each bit 4 cycles;
  - `fifo_renable` high for exactly one cycle (the first start cycle);
  - `tx_done` on cycle 40 of the frame.
- **Parity:** PARITY_EN=1:
  - 0xA5 -> parity bit 0;
  - 0x07 -> parity bit 1;
  - frame length 44 cycles at CLKS_PER_BIT=4.
- **Back-to-back:** FIFO holds 0x55 then 0xAA ->
  - two frames with a single idle cycle between them;
  - two pops total;
  - second frame data bits 0,1,0,1,0,1,0,1;
  - block idles once `fifo_empty`=1.
- **Enable gating:** `enable` dropped in the middle of DATA -> frame completes normally and no second frame starts, even with FIFO non-empty. Re-raising `enable` starts the next frame one cycle later.
- **Reset mid-frame:** `n_rst`=0 during bit 3 of the data -> next cycle `tx_out`=1, `tx_busy`=0, no pop. The FIFO head is unchanged apart from the one pop already made at frame start.
